// File: rtl/add3_final_sum_pipe.sv
// Three-operand final adder: 3:2 carry-save, then a split carry-propagate add.
// Latency: 3 cycles from input accept to out_valid (S1 -> S2 -> S3), 1 beat/cycle sustained.
// Backpressure: per-stage valid; in_ready is combinational from out_ready, and empty stages fill while the output stalls.
module add3_final_sum_pipe #(
  parameter int radix = 78,
  parameter int SPLIT = radix
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*radix-1:0]   res_0,
  input  logic [2*radix-1:0]   res_1,
  input  logic [2*radix-1:0]   res_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*radix-1:0]   prod,
  output logic                 ovf
);

  localparam int W  = 2 * radix;
  localparam int HW = W - SPLIT;   // width of the upper carry-propagate slice

  // ---------------------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------------------
  logic v1_q, v2_q, v3_q;
  logic ready1, ready2, ready3;

  // A stage can take a new beat when it is empty or its contents move on this cycle.
  always_comb begin
    ready3 = !v3_q || out_ready;
    ready2 = !v2_q || ready3;
    ready1 = !v1_q || ready2;
  end

  assign in_ready  = ready1;
  assign out_valid = v3_q;

  // ---------------------------------------------------------------------------
  // Stage 1: 3:2 carry-save compression
  // ---------------------------------------------------------------------------
  logic [W-1:0] maj;
  logic [W-1:0] s1_sum_d, s1_cry_d;
  logic         s1_d1_d;
  logic [W-1:0] s1_sum_q, s1_cry_q;
  logic         s1_d1_q;

  // Bitwise sum and majority; the majority's top bit is weight 2^W and leaves the word.
  always_comb begin
    maj      = (res_0 & res_1) | (res_0 & res_2) | (res_1 & res_2);
    s1_sum_d = res_0 ^ res_1 ^ res_2;
    s1_cry_d = {maj[W-2:0], 1'b0};
    s1_d1_d  = maj[W-1];
  end

  // Stage 1 register: loads a new beat when the stage is free to advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      s1_sum_q <= '0;
      s1_cry_q <= '0;
      s1_d1_q  <= 1'b0;
    end else if (ready1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        s1_sum_q <= s1_sum_d;
        s1_cry_q <= s1_cry_d;
        s1_d1_q  <= s1_d1_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: low-half carry-propagate add
  // ---------------------------------------------------------------------------
  logic [SPLIT:0]   lo_sum_d;
  logic [SPLIT-1:0] s2_lo_q;
  logic             s2_cy_q;
  logic [HW-1:0]    s2_shi_q, s2_chi_q;
  logic             s2_d1_q;

  // Low slice add; bit SPLIT is the carry into the high slice.
  always_comb begin
    lo_sum_d = {1'b0, s1_sum_q[SPLIT-1:0]} + {1'b0, s1_cry_q[SPLIT-1:0]};
  end

  // Stage 2 register: keeps the finished low half, forwards the high operands untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      s2_lo_q  <= '0;
      s2_cy_q  <= 1'b0;
      s2_shi_q <= '0;
      s2_chi_q <= '0;
      s2_d1_q  <= 1'b0;
    end else if (ready2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_lo_q  <= lo_sum_d[SPLIT-1:0];
        s2_cy_q  <= lo_sum_d[SPLIT];
        s2_shi_q <= s1_sum_q[W-1:SPLIT];
        s2_chi_q <= s1_cry_q[W-1:SPLIT];
        s2_d1_q  <= s1_d1_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: high-half add and output register
  // ---------------------------------------------------------------------------
  logic [HW:0]  hi_sum_d;
  logic [W-1:0] prod_q;
  logic         ovf_q;

  // High slice add including the carry from the low slice; bit HW is the word carry-out.
  always_comb begin
    hi_sum_d = {1'b0, s2_shi_q} + {1'b0, s2_chi_q} + {{HW{1'b0}}, s2_cy_q};
  end

  // Output register: result only changes when a valid beat is loaded.
  // Overflow is set by either weight-2^W source (majority top bit or adder carry-out).
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q   <= 1'b0;
      prod_q <= '0;
      ovf_q  <= 1'b0;
    end else if (ready3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        prod_q <= {hi_sum_d[HW-1:0], s2_lo_q};
        ovf_q  <= s2_d1_q | hi_sum_d[HW];
      end
    end
  end

  assign prod = prod_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_add3_final_sum_pipe.sv
// Bench for add3_final_sum_pipe: directed beats with hand-computed results,
// a scoreboard queue filled on accept and drained by an independent output monitor.
module tb_add3_final_sum_pipe;

  localparam int RADIX = 78;
  localparam int SPLIT = 78;
  localparam int W     = 2 * RADIX;

  typedef logic [W-1:0] word_t;
  typedef struct packed {
    logic  ovf;
    word_t prod;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid, in_ready;
  word_t res_0, res_1, res_2;
  logic  out_valid, out_ready;
  word_t prod;
  logic  ovf;

  always #5 clk = ~clk;

  add3_final_sum_pipe #(.radix(RADIX), .SPLIT(SPLIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_0     (res_0),
    .res_1     (res_1),
    .res_2     (res_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .ovf       (ovf)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   out_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   acc_cyc = 0;
  int   last_out_cyc = 0;

  // Output monitor: compares whatever the DUT presents against the oldest expected beat.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        out_cycles.push_back(cyc);
        last_out_cyc = cyc;
      end
      if (sb.size() == 0) begin
        if (out_ready) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got prod=%h ovf=%b, required no output", prod, ovf);
        end
      end else begin
        mon_e = sb[0];
        checks++;
        if (prod !== mon_e.prod || ovf !== mon_e.ovf) begin
          errors++;
          $display("FAIL %s: got prod=%h ovf=%b, required prod=%h ovf=%b",
                   out_ready ? "result" : "stall_hold", prod, ovf, mon_e.prod, mon_e.ovf);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic check_int(input string name, input integer act, input integer req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Present one beat (called just after a rising edge), wait for accept, record expectation.
  task automatic send(input word_t a, input word_t b, input word_t c,
                      input word_t ep, input logic eo);
    int   n;
    exp_t e;
    n = 0;
    res_0 = a; res_1 = b; res_2 = c; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required accept", n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    e.prod = ep;
    e.ovf  = eo;
    sb.push_back(e);
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected beat has left the DUT.
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_int({name, "_drained"}, sb.size(), 0);
  endtask

  function automatic word_t rnd_word();
    word_t r;
    r = '0;
    for (int k = 0; k < 5; k++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  function automatic exp_t ref_sum(input word_t a, input word_t b, input word_t c);
    logic [W+1:0] t;
    exp_t         e;
    t      = {2'b00, a} + {2'b00, b} + {2'b00, c};
    e.prod = t[W-1:0];
    e.ovf  = |t[W+1:W];
    return e;
  endfunction

  word_t t5_a[4], t5_b[4], t5_c[4], t5_p[4];
  logic  t5_o[4];

  initial begin
    word_t a, b, c;
    exp_t  e;
    int    t1_acc, acc5, idx;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    res_0 = '0; res_1 = '0; res_2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("reset_out_valid", {31'b0, out_valid}, 0);
    check_word("reset_prod", prod, '0);
    check_int("reset_ovf", {31'b0, ovf}, 0);
    check_int("reset_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1) basic sum and latency
    send(word_t'(1), word_t'(2), word_t'(3), word_t'(6), 1'b0);
    t1_acc = acc_cyc;
    drain("t1");
    check_int("t1_latency", last_out_cyc - t1_acc, 3);

    // 2) carry across the split; 3) overflow corner cases (back-to-back)
    send((word_t'(1) << SPLIT) - word_t'(1), word_t'(1), '0, word_t'(1) << SPLIT, 1'b0);
    send('1, '1, '1, ~word_t'(2), 1'b1);
    send(word_t'(1) << (W-1), word_t'(1) << (W-1), word_t'(1) << (W-1), word_t'(1) << (W-1), 1'b1);
    send('1, word_t'(1), '0, '0, 1'b1);
    send(word_t'(1) << (SPLIT-1), word_t'(1) << (SPLIT-1), '0, word_t'(1) << SPLIT, 1'b0);
    drain("t23");

    // 4) ten back-to-back beats against the reference model
    out_cycles.delete();
    for (int i = 0; i < 10; i++) begin
      a = rnd_word(); b = rnd_word(); c = rnd_word();
      if (i == 0) begin a = '1; b = '1; c = '1; end
      e = ref_sum(a, b, c);
      send(a, b, c, e.prod, e.ovf);
    end
    drain("t4");
    check_int("t4_count", out_cycles.size(), 10);
    check_int("t4_consecutive", out_cycles[9] - out_cycles[0], 9);

    // 5) output stall with continuous input
    t5_a[0] = word_t'(10);  t5_b[0] = word_t'(20);  t5_c[0] = word_t'(30);  t5_p[0] = word_t'(60);  t5_o[0] = 1'b0;
    t5_a[1] = '1;           t5_b[1] = '1;           t5_c[1] = '0;           t5_p[1] = ~word_t'(1);  t5_o[1] = 1'b1;
    t5_a[2] = word_t'(100); t5_b[2] = word_t'(200); t5_c[2] = word_t'(300); t5_p[2] = word_t'(600); t5_o[2] = 1'b0;
    t5_a[3] = word_t'(7);   t5_b[3] = '0;           t5_c[3] = '0;           t5_p[3] = word_t'(7);   t5_o[3] = 1'b0;
    out_ready = 1'b0;
    acc5 = 0;
    idx  = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      res_0 = t5_a[idx]; res_1 = t5_b[idx]; res_2 = t5_c[idx];
      @(negedge clk);
      if (in_ready && idx < 4) begin
        e.prod = t5_p[idx];
        e.ovf  = t5_o[idx];
        sb.push_back(e);
        acc5++;
        idx++;
      end
      @(posedge clk); #1;
    end
    check_int("t5_accepts", acc5, 3);
    check_int("t5_in_ready_low", {31'b0, in_ready}, 0);
    check_int("t5_out_valid_held", {31'b0, out_valid}, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("t5");

    // 6) reset with two beats in flight
    send(word_t'(5), word_t'(5), word_t'(5), word_t'(15), 1'b0);
    send(word_t'(9), word_t'(9), word_t'(9), word_t'(27), 1'b0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check_int("t6_out_valid", {31'b0, out_valid}, 0);
    check_word("t6_prod", prod, '0);
    check_int("t6_ovf", {31'b0, ovf}, 0);
    check_int("t6_in_ready", {31'b0, in_ready}, 1);
    rst = 1'b0;
    out_cycles.delete();
    repeat (8) @(posedge clk);
    #1;
    check_int("t6_no_stale_beat", out_cycles.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
